async_fifo_ptr_ctrl_v2: RTL and testbench



---
 rtl/async_fifo_ptr_ctrl_v2_if.sv | 27 ++
 rtl/async_fifo_ptr_ctrl_v2.sv | 123 ++++++++++++
 tb/tb_async_fifo_ptr_ctrl_v2.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_ptr_ctrl_v2_if.sv
// Local-side handshake bundle of one async FIFO pointer controller.
// The master drives requests and the remote Gray pointer; the controller (slave) returns RAM control and status.
interface async_fifo_ptr_ctrl_v2_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  clear;
  logic                  inc;
  logic [ADDR_WIDTH:0]   ptr_gray_other;
  logic                  cen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   ptr_gray;
  logic [ADDR_WIDTH:0]   ptr_bin;
  logic [ADDR_WIDTH:0]   level;
  logic                  blocked;
  logic                  almost;
  logic                  err;

  modport master (
    output clear, inc, ptr_gray_other,
    input  cen, addr, ptr_gray, ptr_bin, level, blocked, almost, err
  );

  modport slave (
    input  clear, inc, ptr_gray_other,
    output cen, addr, ptr_gray, ptr_bin, level, blocked, almost, err
  );
endinterface

// File: rtl/async_fifo_ptr_ctrl_v2.sv
// One side (write when SIDE=0, read when SIDE=1) of an async FIFO pointer pair.
// Depth may be any value up to 2^ADDR_WIDTH; the Gray sequence is offset so that its wrap stays single-bit.
module async_fifo_ptr_ctrl_v2 #(
  parameter int ADDR_WIDTH  = 5,
  parameter int FIFO_DEPTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0,
  parameter int ALMOST_TH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  async_fifo_ptr_ctrl_v2_if.slave  bus
);
  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] ONE        = PW'(1);
  localparam logic [PW-1:0] DEPTH      = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST       = PW'(2 * FIFO_DEPTH - 1);
  localparam logic [PW-1:0] OFFSET     = PW'((1 << ADDR_WIDTH) - FIFO_DEPTH);
  localparam logic [PW-1:0] AFULL_LVL  = PW'(FIFO_DEPTH - ALMOST_TH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(ALMOST_TH);
  localparam logic [PW:0]   SPAN       = (PW + 1)'(2 * FIFO_DEPTH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  localparam logic [PW-1:0] GRAY_RST = bin2gray(OFFSET);

  logic [PW-1:0] ptr_bin_q, ptr_bin_d;
  logic [PW-1:0] ptr_gray_q, ptr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          blocked_q, blocked_d;
  logic          almost_q, almost_d;
  logic          err_q, err_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;

  logic          adv;
  logic [PW-1:0] other_lin;
  logic [PW-1:0] minuend;
  logic [PW-1:0] subtrahend;
  logic [PW-1:0] addr_lin;

  always_comb begin
    adv = bus.inc & ~blocked_q & ~bus.clear;

    ptr_bin_d = ptr_bin_q;
    if (bus.clear) begin
      ptr_bin_d = '0;
    end else if (adv) begin
      ptr_bin_d = (ptr_bin_q == LAST) ? '0 : ptr_bin_q + ONE;
    end
    ptr_gray_d = bin2gray(ptr_bin_d + OFFSET);

    other_lin = gray2bin(sync_q[SYNC_STAGES-1]) - OFFSET;

    // Occupancy is always "producer minus consumer", taken modulo 2*FIFO_DEPTH.
    if (SIDE == 0) begin
      minuend    = ptr_bin_d;
      subtrahend = other_lin;
    end else begin
      minuend    = other_lin;
      subtrahend = ptr_bin_d;
    end
    if (minuend >= subtrahend) begin
      level_d = minuend - subtrahend;
    end else begin
      level_d = PW'({1'b0, minuend} + SPAN - {1'b0, subtrahend});
    end

    if (SIDE == 0) begin
      blocked_d = (level_d == DEPTH);
      almost_d  = (level_d >= AFULL_LVL);
    end else begin
      blocked_d = (level_d == '0);
      almost_d  = (level_d <= AEMPTY_LVL);
    end

    err_d = bus.clear ? 1'b0 : (err_q | (bus.inc & blocked_q));

    addr_lin = (ptr_bin_q < DEPTH) ? ptr_bin_q : ptr_bin_q - DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= GRAY_RST;
      level_q    <= '0;
      blocked_q  <= (SIDE != 0);
      almost_q   <= 1'b1;
      err_q      <= 1'b0;
      sync_q     <= {SYNC_STAGES{GRAY_RST}};
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      level_q    <= level_d;
      blocked_q  <= blocked_d;
      almost_q   <= almost_d;
      err_q      <= err_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.ptr_gray_other};
    end
  end

  // ptr_gray leaves the block straight from its flop so the far side never samples a glitch.
  assign bus.ptr_gray = ptr_gray_q;
  assign bus.ptr_bin  = ptr_bin_q;
  assign bus.level    = level_q;
  assign bus.blocked  = blocked_q;
  assign bus.almost   = almost_q;
  assign bus.err      = err_q;
  assign bus.cen      = ~adv;
  assign bus.addr     = addr_lin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_async_fifo_ptr_ctrl_v2.sv
// Directed checks on a stand-alone write and read controller, then randomized
// two-clock runs of full write/read pairs against a queue-based FIFO model.
module tb_async_fifo_ptr_ctrl_v2;
  logic wclk = 1'b0;
  logic rclk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 wclk = ~wclk;
  always begin
    #13 rclk = 1'b1;
    #14 rclk = 1'b0;
  end

  localparam logic [5:0] G_RST = 6'b001100;
  localparam logic [5:0] G_47  = 6'b101100;

  // Gray code for linear pointer lin with FIFO_DEPTH=24, ADDR_WIDTH=5 (offset 8).
  function automatic logic [5:0] gray_of(input int lin);
    logic [5:0] b;
    b = 6'(lin + 8);
    return b ^ (b >> 1);
  endfunction

  function automatic int dep(input int k);
    return (k == 0) ? 5 : ((k == 1) ? 24 : 32);
  endfunction

  // Directed instances, depth 24, both on wclk.
  async_fifo_ptr_ctrl_v2_if #(.ADDR_WIDTH(5)) dw_if ();
  async_fifo_ptr_ctrl_v2_if #(.ADDR_WIDTH(5)) dr_if ();

  async_fifo_ptr_ctrl_v2 #(.ADDR_WIDTH(5), .FIFO_DEPTH(24), .SYNC_STAGES(2), .SIDE(0), .ALMOST_TH(4))
    u_dw (.clk(wclk), .rst_n(rst_n), .bus(dw_if));
  async_fifo_ptr_ctrl_v2 #(.ADDR_WIDTH(5), .FIFO_DEPTH(24), .SYNC_STAGES(2), .SIDE(1), .ALMOST_TH(4))
    u_dr (.clk(wclk), .rst_n(rst_n), .bus(dr_if));

  // Randomized write/read pairs on independent clocks.
  logic [2:0] w_inc, r_inc, w_cen, r_cen, w_blocked, r_blocked;
  logic [5:0] w_gray [3];
  logic [5:0] r_gray [3];
  logic [5:0] w_ptr [3];
  logic [5:0] w_level [3];
  logic [5:0] r_level [3];
  logic [4:0] w_addr [3];
  logic [4:0] r_addr [3];
  logic [7:0] mem [3][32];
  logic [7:0] q [$];
  logic [5:0] w_prev, r_prev;

  for (genvar gi = 0; gi < 3; gi++) begin : g_pair
    localparam int D  = (gi == 0) ? 5 : ((gi == 1) ? 24 : 32);
    localparam int S  = (gi == 0) ? 3 : 2;
    localparam int TH = (gi == 0) ? 2 : 4;

    async_fifo_ptr_ctrl_v2_if #(.ADDR_WIDTH(5)) wif ();
    async_fifo_ptr_ctrl_v2_if #(.ADDR_WIDTH(5)) rif ();

    async_fifo_ptr_ctrl_v2 #(.ADDR_WIDTH(5), .FIFO_DEPTH(D), .SYNC_STAGES(S), .SIDE(0), .ALMOST_TH(TH))
      u_w (.clk(wclk), .rst_n(rst_n), .bus(wif));
    async_fifo_ptr_ctrl_v2 #(.ADDR_WIDTH(5), .FIFO_DEPTH(D), .SYNC_STAGES(S), .SIDE(1), .ALMOST_TH(TH))
      u_r (.clk(rclk), .rst_n(rst_n), .bus(rif));

    assign wif.clear          = 1'b0;
    assign wif.inc            = w_inc[gi];
    assign wif.ptr_gray_other = rif.ptr_gray;
    assign rif.clear          = 1'b0;
    assign rif.inc            = r_inc[gi];
    assign rif.ptr_gray_other = wif.ptr_gray;

    assign w_cen[gi]     = wif.cen;
    assign r_cen[gi]     = rif.cen;
    assign w_blocked[gi] = wif.blocked;
    assign r_blocked[gi] = rif.blocked;
    assign w_gray[gi]    = wif.ptr_gray;
    assign r_gray[gi]    = rif.ptr_gray;
    assign w_ptr[gi]     = wif.ptr_bin;
    assign w_level[gi]   = wif.level;
    assign r_level[gi]   = rif.level;
    assign w_addr[gi]    = wif.addr;
    assign r_addr[gi]    = rif.addr;
  end

  task automatic test_reset();
    w_inc = '0;
    r_inc = '0;
    dw_if.clear = 1'b0; dw_if.inc = 1'b0; dw_if.ptr_gray_other = G_RST;
    dr_if.clear = 1'b0; dr_if.inc = 1'b0; dr_if.ptr_gray_other = G_RST;
    rst_n = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    checks++; if (dw_if.ptr_gray !== G_RST) begin errors++; $display("FAIL rst_gray got %b want %b", dw_if.ptr_gray, G_RST); end
    checks++; if (dw_if.ptr_bin !== 6'd0) begin errors++; $display("FAIL rst_ptr got %0d want 0", dw_if.ptr_bin); end
    checks++; if (dw_if.level !== 6'd0) begin errors++; $display("FAIL rst_level got %0d want 0", dw_if.level); end
    checks++; if (dw_if.blocked !== 1'b0) begin errors++; $display("FAIL rst_wblocked got %b want 0", dw_if.blocked); end
    checks++; if (dw_if.almost !== 1'b1) begin errors++; $display("FAIL rst_walmost got %b want 1", dw_if.almost); end
    checks++; if (dw_if.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", dw_if.err); end
    checks++; if (dw_if.cen !== 1'b1) begin errors++; $display("FAIL rst_cen got %b want 1", dw_if.cen); end
    checks++; if (dr_if.blocked !== 1'b1) begin errors++; $display("FAIL rst_rblocked got %b want 1", dr_if.blocked); end
    @(negedge wclk);
    rst_n = 1'b1;
    @(posedge wclk);
    #1;
    checks++; if (dw_if.almost !== 1'b0) begin errors++; $display("FAIL post_rst_walmost got %b want 0", dw_if.almost); end
    checks++; if (dw_if.blocked !== 1'b0) begin errors++; $display("FAIL post_rst_wblocked got %b want 0", dw_if.blocked); end
    checks++; if (dr_if.blocked !== 1'b1) begin errors++; $display("FAIL post_rst_rblocked got %b want 1", dr_if.blocked); end
    checks++; if (dr_if.almost !== 1'b1) begin errors++; $display("FAIL post_rst_ralmost got %b want 1", dr_if.almost); end
    $display("reset: released, write side empty, read side blocked");
  endtask

  task automatic test_fill_overflow();
    int cnt = 0;
    dw_if.ptr_gray_other = G_RST;
    for (int c = 0; c < 300 && cnt < 24; c++) begin
      dw_if.inc = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (dw_if.cen !== !dw_if.inc) begin errors++; $display("FAIL fill_cen got %b want %b", dw_if.cen, !dw_if.inc); end
      @(posedge wclk);
      #1;
      if (dw_if.inc) cnt++;
      checks++; if (dw_if.ptr_bin !== 6'(cnt)) begin errors++; $display("FAIL fill_ptr got %0d want %0d", dw_if.ptr_bin, cnt); end
      checks++; if (dw_if.level !== 6'(cnt)) begin errors++; $display("FAIL fill_level got %0d want %0d", dw_if.level, cnt); end
      checks++; if (dw_if.blocked !== (cnt == 24)) begin errors++; $display("FAIL fill_full got %b at level %0d", dw_if.blocked, cnt); end
      checks++; if (dw_if.almost !== (cnt >= 20)) begin errors++; $display("FAIL fill_almost got %b at level %0d", dw_if.almost, cnt); end
      checks++; if (dw_if.ptr_gray !== gray_of(cnt)) begin errors++; $display("FAIL fill_gray got %b want %b", dw_if.ptr_gray, gray_of(cnt)); end
    end
    checks++; if (cnt != 24) begin errors++; $display("FAIL fill_timeout pushes %0d want 24", cnt); end
    dw_if.inc = 1'b1;
    #1;
    checks++; if (dw_if.cen !== 1'b1) begin errors++; $display("FAIL ovf_cen got %b want 1", dw_if.cen); end
    @(posedge wclk);
    #1;
    checks++; if (dw_if.ptr_bin !== 6'd24) begin errors++; $display("FAIL ovf_ptr got %0d want 24", dw_if.ptr_bin); end
    checks++; if (dw_if.err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", dw_if.err); end
    checks++; if (dw_if.level !== 6'd24) begin errors++; $display("FAIL ovf_level got %0d want 24", dw_if.level); end
    dw_if.inc = 1'b0;
    $display("fill: %0d pushes, overflow attempt rejected", cnt);
  endtask

  task automatic test_remote_and_wrap();
    logic [5:0] g_prev;
    dw_if.ptr_gray_other = gray_of(24);
    for (int e = 1; e <= 3; e++) begin
      @(posedge wclk);
      #1;
      checks++; if (dw_if.level !== ((e < 3) ? 6'd24 : 6'd0)) begin errors++; $display("FAIL remote_level edge %0d got %0d", e, dw_if.level); end
      checks++; if (dw_if.blocked !== (e < 3)) begin errors++; $display("FAIL remote_full edge %0d got %b", e, dw_if.blocked); end
    end
    checks++; if (dw_if.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", dw_if.err); end
    dw_if.inc = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      @(posedge wclk);
      #1;
      checks++; if (dw_if.ptr_bin !== 6'(24 + i)) begin errors++; $display("FAIL wrap_ptr got %0d want %0d", dw_if.ptr_bin, 24 + i); end
      checks++; if (dw_if.addr !== 5'(i)) begin errors++; $display("FAIL wrap_addr got %0d want %0d", dw_if.addr, i); end
      checks++; if (dw_if.level !== 6'(i)) begin errors++; $display("FAIL wrap_level got %0d want %0d", dw_if.level, i); end
    end
    checks++; if (dw_if.ptr_gray !== G_47) begin errors++; $display("FAIL gray_47 got %b want %b", dw_if.ptr_gray, G_47); end
    checks++; if (dw_if.cen !== 1'b0) begin errors++; $display("FAIL wrap_cen got %b want 0", dw_if.cen); end
    g_prev = dw_if.ptr_gray;
    @(posedge wclk);
    #1;
    dw_if.inc = 1'b0;
    checks++; if (dw_if.ptr_bin !== 6'd0) begin errors++; $display("FAIL wrap_ptr0 got %0d want 0", dw_if.ptr_bin); end
    checks++; if (dw_if.ptr_gray !== G_RST) begin errors++; $display("FAIL wrap_gray got %b want %b", dw_if.ptr_gray, G_RST); end
    checks++; if ($countones(dw_if.ptr_gray ^ g_prev) != 1) begin errors++; $display("FAIL wrap_hamming got %b from %b", dw_if.ptr_gray, g_prev); end
    checks++; if (dw_if.addr !== 5'd0) begin errors++; $display("FAIL wrap_addr0 got %0d want 0", dw_if.addr); end
    checks++; if (dw_if.level !== 6'd24) begin errors++; $display("FAIL wrap_level24 got %0d want 24", dw_if.level); end
    checks++; if (dw_if.blocked !== 1'b1) begin errors++; $display("FAIL wrap_full got %b want 1", dw_if.blocked); end
    $display("wrap: pointer 47 -> 0, gray %b -> %b", g_prev, dw_if.ptr_gray);
  endtask

  task automatic test_clear_with_inc();
    dw_if.ptr_gray_other = gray_of(0);
    repeat (3) @(posedge wclk);
    #1;
    checks++; if (dw_if.level !== 6'd0) begin errors++; $display("FAIL clr_pre_level got %0d want 0", dw_if.level); end
    dw_if.inc = 1'b1;
    repeat (10) @(posedge wclk);
    #1;
    dw_if.inc = 1'b0;
    checks++; if (dw_if.ptr_bin !== 6'd10) begin errors++; $display("FAIL clr_pre_ptr got %0d want 10", dw_if.ptr_bin); end
    checks++; if (dw_if.err !== 1'b1) begin errors++; $display("FAIL clr_pre_err got %b want 1", dw_if.err); end
    dw_if.clear = 1'b1;
    dw_if.inc = 1'b1;
    #1;
    checks++; if (dw_if.cen !== 1'b1) begin errors++; $display("FAIL clr_cen got %b want 1", dw_if.cen); end
    @(posedge wclk);
    #1;
    dw_if.clear = 1'b0;
    dw_if.inc = 1'b0;
    checks++; if (dw_if.ptr_bin !== 6'd0) begin errors++; $display("FAIL clr_ptr got %0d want 0", dw_if.ptr_bin); end
    checks++; if (dw_if.err !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", dw_if.err); end
    checks++; if (dw_if.ptr_gray !== G_RST) begin errors++; $display("FAIL clr_gray got %b want %b", dw_if.ptr_gray, G_RST); end
    checks++; if (dw_if.level !== 6'd0) begin errors++; $display("FAIL clr_level got %0d want 0", dw_if.level); end
    checks++; if (dw_if.blocked !== 1'b0 || dw_if.almost !== 1'b0) begin errors++; $display("FAIL clr_flags got full %b almost %b want 0 0", dw_if.blocked, dw_if.almost); end
    $display("clear+inc: pointer 10 -> %0d, err -> %b", dw_if.ptr_bin, dw_if.err);
  endtask

  task automatic test_read_side();
    checks++; if (dr_if.blocked !== 1'b1) begin errors++; $display("FAIL rd_empty got %b want 1", dr_if.blocked); end
    dr_if.inc = 1'b1;
    #1;
    checks++; if (dr_if.cen !== 1'b1) begin errors++; $display("FAIL rd_udf_cen got %b want 1", dr_if.cen); end
    @(posedge wclk);
    #1;
    dr_if.inc = 1'b0;
    checks++; if (dr_if.err !== 1'b1 || dr_if.ptr_bin !== 6'd0) begin errors++; $display("FAIL rd_udf got err %b ptr %0d want 1 0", dr_if.err, dr_if.ptr_bin); end
    dr_if.ptr_gray_other = gray_of(3);
    for (int e = 1; e <= 3; e++) begin
      @(posedge wclk);
      #1;
      checks++; if (dr_if.blocked !== (e < 3)) begin errors++; $display("FAIL rd_sync_empty edge %0d got %b", e, dr_if.blocked); end
      checks++; if (dr_if.level !== ((e < 3) ? 6'd0 : 6'd3)) begin errors++; $display("FAIL rd_sync_level edge %0d got %0d", e, dr_if.level); end
    end
    checks++; if (dr_if.almost !== 1'b1) begin errors++; $display("FAIL rd_almost got %b want 1", dr_if.almost); end
    dr_if.inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (dr_if.cen !== 1'b0) begin errors++; $display("FAIL rd_pop_cen pop %0d got %b", i, dr_if.cen); end
      @(posedge wclk);
      #1;
      checks++; if (dr_if.level !== 6'(3 - i)) begin errors++; $display("FAIL rd_pop_level got %0d want %0d", dr_if.level, 3 - i); end
      checks++; if (dr_if.blocked !== (i == 3)) begin errors++; $display("FAIL rd_pop_empty pop %0d got %b", i, dr_if.blocked); end
      checks++; if (dr_if.ptr_bin !== 6'(i)) begin errors++; $display("FAIL rd_pop_ptr got %0d want %0d", dr_if.ptr_bin, i); end
    end
    #1;
    checks++; if (dr_if.cen !== 1'b1) begin errors++; $display("FAIL rd_empty_cen got %b want 1", dr_if.cen); end
    dr_if.inc = 1'b0;
    dr_if.clear = 1'b1;
    @(posedge wclk);
    #1;
    dr_if.clear = 1'b0;
    checks++; if (dr_if.err !== 1'b0 || dr_if.ptr_bin !== 6'd0) begin errors++; $display("FAIL rd_clr got err %b ptr %0d want 0 0", dr_if.err, dr_if.ptr_bin); end
    checks++; if (dr_if.level !== 6'd3 || dr_if.blocked !== 1'b0) begin errors++; $display("FAIL rd_clr_level got %0d empty %b want 3 0", dr_if.level, dr_if.blocked); end
    $display("read side: 3 entries seen after sync, drained, cleared");
  endtask

  task automatic wr_step(input int k);
    logic [7:0] d;
    @(negedge wclk);
    w_inc[k] = ($urandom_range(0, 9) < 6);
    #1;
    checks++; if (w_gray[k] != w_prev && $countones(w_gray[k] ^ w_prev) != 1) begin errors++; $display("FAIL w_hamming d%0d got %b from %b", dep(k), w_gray[k], w_prev); end
    w_prev = w_gray[k];
    checks++; if (int'(w_ptr[k]) >= 2 * dep(k) || int'(w_addr[k]) >= dep(k)) begin errors++; $display("FAIL w_range d%0d ptr %0d addr %0d", dep(k), w_ptr[k], w_addr[k]); end
    if (w_cen[k] === 1'b0) begin
      checks++; if (q.size() >= dep(k)) begin errors++; $display("FAIL push_full d%0d occupancy %0d", dep(k), q.size()); end
      d = 8'($urandom);
      mem[k][w_addr[k]] = d;
      q.push_back(d);
    end
  endtask

  task automatic rd_step(input int k, input logic force_inc);
    logic [7:0] exp_d;
    @(negedge rclk);
    r_inc[k] = force_inc ? 1'b1 : ($urandom_range(0, 9) < 8);
    #1;
    checks++; if (r_gray[k] != r_prev && $countones(r_gray[k] ^ r_prev) != 1) begin errors++; $display("FAIL r_hamming d%0d got %b from %b", dep(k), r_gray[k], r_prev); end
    r_prev = r_gray[k];
    if (r_cen[k] === 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL pop_empty d%0d addr %0d", dep(k), r_addr[k]);
      end else begin
        exp_d = q.pop_front();
        checks++; if (mem[k][r_addr[k]] !== exp_d) begin errors++; $display("FAIL data_order d%0d got %h want %h", dep(k), mem[k][r_addr[k]], exp_d); end
      end
    end
  endtask

  task automatic test_random(input int k);
    q.delete();
    w_prev = w_gray[k];
    r_prev = r_gray[k];
    fork
      begin
        for (int c = 0; c < 600; c++) wr_step(k);
        @(posedge wclk);
        #1;
        w_inc[k] = 1'b0;
      end
      begin
        for (int c = 0; c < 220; c++) rd_step(k, 1'b0);
        @(posedge rclk);
        #1;
        r_inc[k] = 1'b0;
      end
    join
    for (int c = 0; c < 200; c++) rd_step(k, 1'b1);
    @(posedge rclk);
    #1;
    r_inc[k] = 1'b0;
    repeat (10) @(posedge wclk);
    #1;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_queue d%0d left %0d want 0", dep(k), q.size()); end
    checks++; if (r_blocked[k] !== 1'b1 || r_level[k] !== 6'd0) begin errors++; $display("FAIL drain_read d%0d empty %b level %0d", dep(k), r_blocked[k], r_level[k]); end
    checks++; if (w_blocked[k] !== 1'b0 || w_level[k] !== 6'd0) begin errors++; $display("FAIL drain_write d%0d full %b level %0d", dep(k), w_blocked[k], w_level[k]); end
    $display("random depth %0d: drained, write ptr %0d", dep(k), w_ptr[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_overflow();
    test_remote_and_wrap();
    test_clear_with_inc();
    test_read_side();
    for (int k = 0; k < 3; k++) test_random(k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
